mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Single-port memory arbiter for the MIPS32 pipeline. Shares one 1024×32 word-addressed memory between the instruction-fetch requester (IF) and the data requester (MEM stage LW/SW). Data accesses have priority. A starvation counter guarantees IF forward progress, and halt/flush inputs sequence fetch around HLT and taken branches.

## Interface
- AW, 10, word-address width (memory depth 2^AW)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied IF cycles before IF gets priority (1..15)

- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- if_req  in  1  IF read request
- if_addr  in  AW  IF word address (PC)
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DW  instruction word
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data word address (ALUOut)
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DW  load data
- halt  in  1  level; blocks all IF grants while high
- if_flush  in  1  pulse; cancels the in-flight IF read and blocks the IF grant in the same cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en && !mem_we

## Operation
- Grants are combinational from the requests and registered state. At most one grant per cycle. mem_en equals if_gnt | dm_gnt. mem_* fields are muxed from the winner.
- IF is eligible when `if_req && !halt && !if_flush`.
- Priority FSM, two states:
  - DM_FIRST (reset state): dm wins any conflict.
  - IF_FIRST: IF wins a conflict if eligible; otherwise dm is served.
  - DM_FIRST→IF_FIRST when the starve count reaches STARVE_MAX.
  - IF_FIRST→DM_FIRST on the cycle after any if_gnt.
- Starve counter (4 bits):
  - Increments each cycle IF is eligible but not granted.
  - Clears on if_gnt, or when IF is not eligible.
  - Saturates at STARVE_MAX.
- Read tracking: one registered in-flight tag (valid + owner) is set on each read grant.
  - Next cycle, the tagged owner's rvalid = 1 and its rdata = mem_rdata.
  - Writes set no tag and produce no rvalid.
- Flush: if_flush high while the tag owner is IF suppresses if_rvalid that cycle. A dm tag is unaffected.
- Halt: halt high leaves any pending IF read to complete normally. No new IF grants. dm is served normally, so in-flight stores drain.
- Addresses wrap modulo 2^AW. No range error.
- rdata of a non-valid port holds its last value. Consumers must qualify with rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as req, if it wins). Read data latency: 1 cycle after grant.
- Requester holds req/addr/wdata until gnt. Deasserting req before gnt is legal; the request is dropped.
- Back-to-back grants every cycle are allowed. Sustained throughput is 1 access/cycle.
- Simultaneous if_req and dm_req: winner per FSM state. The loser sees gnt = 0 and keeps requesting.
- While rst_n = 0 at a posedge, all of these reset to 0: FSM = DM_FIRST, counter, tag valid, if_rvalid, dm_rvalid, if_rdata, dm_rdata.
- While rst_n = 0, if_gnt, dm_gnt, mem_en and mem_we are forced 0 combinationally.
- Reset mid-read: the tag is cleared and no rvalid follows.
- if_flush and halt in the same cycle: both apply; no IF grant.

## Structure
- Package mips_mem_pkg: AW/DW defaults, owner enum (OWN_IF, OWN_DM), priority-state enum (DM_FIRST, IF_FIRST).
- Sub-module arb_starve_ctr: saturating counter with inc/clr inputs and a hit = (count == STARVE_MAX) output.
- Memory array is external. Connect via mem_* ports; the bench supplies a 1-cycle-latency model.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with both reqs high → all grants, mem_en and rvalids are 0. On release, first cycle: dm_gnt = 1.
- **Isolated IF read:** if_req = 1, if_addr = 0x005, mem[5] = 0x2800000A → if_gnt same cycle, if_rvalid next cycle, if_rdata = 0x2800000A.
- **Contention/starvation (STARVE_MAX = 4):** both reqs held continuously → dm granted 4 cycles, IF granted in cycle 5, dm in cycle 6. The pattern repeats 4:1.
- **Store then load, same address:** dm store of 0x000000AB to address 0x3FF, then dm load of 0x3FF → dm_rvalid one cycle after the load grant, dm_rdata = 0x000000AB. No dm_rvalid for the store.
- **Flush:** IF read granted at cycle N, if_flush = 1 at cycle N+1 → if_rvalid = 0 at N+1. IF is not granted at N+1 even with if_req = 1.
- **Halt drain:** halt = 1 with if_req and dm store pending → IF never granted. Store granted, mem_we = 1 for one cycle. Starve counter stays 0.

Source files
------------

// File: rtl/mips_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared defaults and enums for the MIPS32 single-port memory arbiter.
//   AW_DEF / DW_DEF   : default word-address / data widths
//   STARVE_MAX_DEF    : default denied-IF cycles before IF is favoured
//   owner_e           : owner of the in-flight read tag
//   prio_e            : arbitration priority state
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int AW_DEF         = 10;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    typedef enum logic {
        DM_FIRST = 1'b0,
        IF_FIRST = 1'b1
    } prio_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter_if
// Bundles the fetch port, data port, fetch control and external memory
// port of the arbiter.
//   slave  : arbiter view (requests/controls/mem_rdata in; grants, read
//            responses and memory strobes out)
//   master : requester + memory-model view (mirror of slave)
// ---------------------------------------------------------------------------
interface mips_mem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    // instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // data port
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    // fetch sequencing
    logic          halt;
    logic          if_flush;

    // external memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               halt, if_flush, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               halt, if_flush, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mips_mem_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// 4-bit saturating counter of consecutive cycles the fetch port was
// eligible but denied.
//   clk, rst_n : clock, synchronous active-low reset
//   i_inc      : count one more denied cycle (saturates at STARVE_MAX)
//   i_clr      : clear (wins over i_inc)
//   o_hit      : count == STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != MAX_C))
            r_count <= r_count + 4'd1;
    end

    assign o_hit = (r_count == MAX_C);

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
// Shares one 1-cycle-latency single-port memory between instruction fetch
// and the MEM-stage data port. Data wins conflicts unless fetch has been
// starved for STARVE_MAX cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mips_mem_arbiter_if.slave (fetch port, data port,
//                halt/if_flush, external memory port)
// Grants are combinational (0-cycle), read data returns the next cycle.
// ---------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DW         = DW_DEF,      // must match the bus instance
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_mem_arbiter_if.slave      bus
);

    logic    w_if_elig;
    logic    w_if_pri;
    logic    w_if_gnt;
    logic    w_dm_gnt;
    logic    w_rd_gnt;
    logic    w_hit;
    logic    w_if_rvalid;
    logic    w_dm_rvalid;

    prio_e   r_state;
    logic    r_tag_vld;
    owner_e  r_tag_own;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;

    // ---------------- grant logic ----------------
    assign w_if_elig = bus.if_req && !bus.halt && !bus.if_flush;

    // The counter hitting its limit favours IF in that very cycle; the
    // IF_FIRST state only remembers the debt if IF could not take it
    // (e.g. it went ineligible), since the counter itself clears then.
    assign w_if_pri  = (r_state == IF_FIRST) || w_hit;

    assign w_if_gnt  = rst_n && w_if_elig && (w_if_pri || !bus.dm_req);
    assign w_dm_gnt  = rst_n && bus.dm_req && !w_if_gnt;
    assign w_rd_gnt  = w_if_gnt || (w_dm_gnt && !bus.dm_we);

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.mem_en    = w_if_gnt || w_dm_gnt;
    assign bus.mem_we    = w_dm_gnt && bus.dm_we;
    assign bus.mem_addr  = w_if_gnt ? bus.if_addr : bus.dm_addr;
    assign bus.mem_wdata = bus.dm_wdata;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_if_elig && !w_if_gnt),
        .i_clr (w_if_gnt || !w_if_elig),
        .o_hit (w_hit)
    );

    // ---------------- priority FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DM_FIRST;
        end else begin
            case (r_state)
                DM_FIRST: if (w_hit && !w_if_gnt) r_state <= IF_FIRST;
                IF_FIRST: if (w_if_gnt)           r_state <= DM_FIRST;
                default:                          r_state <= DM_FIRST;
            endcase
        end
    end

    // ---------------- read tracking ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_vld <= 1'b0;
            r_tag_own <= OWN_IF;
        end else begin
            r_tag_vld <= w_rd_gnt;
            r_tag_own <= w_if_gnt ? OWN_IF : OWN_DM;
        end
    end

    // rvalid is gated by rst_n so a read caught by reset never reports.
    assign w_if_rvalid = rst_n && r_tag_vld && (r_tag_own == OWN_IF) && !bus.if_flush;
    assign w_dm_rvalid = rst_n && r_tag_vld && (r_tag_own == OWN_DM);

    // mem_rdata passes straight through on the response cycle; the hold
    // registers keep the last delivered word visible afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_if_rvalid) r_if_rdata <= bus.mem_rdata;
            if (w_dm_rvalid) r_dm_rdata <= bus.mem_rdata;
        end
    end

    assign bus.if_rvalid = w_if_rvalid;
    assign bus.dm_rvalid = w_dm_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : r_if_rdata;
    assign bus.dm_rdata  = w_dm_rvalid ? bus.mem_rdata : r_dm_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int NV   = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_mem = 1'b1;
    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mips_mem_arbiter #(.DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'h2800000A;
        return 32'hC0DE0000 + 32'(i) * 32'd65537;
    endfunction

    // 1-cycle-latency memory model
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dwe,
                         input logic [9:0] da, input logic [31:0] dwd, input logic h, input logic f);
        bus.if_req = ir; bus.if_addr = ia; bus.dm_req = dr; bus.dm_we = dwe;
        bus.dm_addr = da; bus.dm_wdata = dwd; bus.halt = h; bus.if_flush = f;
    endtask

    typedef struct {
        logic ir; logic [9:0] ia; logic dr; logic dwe; logic [9:0] da; logic [31:0] dwd;
        logic h; logic f;
        logic eig; logic edg; logic ewe; logic eirv; logic edrv; logic [31:0] erd;
    } vec_t;

    function automatic vec_t mkv(logic ir, logic [9:0] ia, logic dr, logic dwe, logic [9:0] da,
                                 logic [31:0] dwd, logic h, logic f, logic eig, logic edg,
                                 logic ewe, logic eirv, logic edrv, logic [31:0] erd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.h = h; v.f = f;
        v.eig = eig; v.edg = edg; v.ewe = ewe; v.eirv = eirv; v.edrv = edrv; v.erd = erd;
        return v;
    endfunction

    vec_t vt [NV];
    logic [DW-1:0] ref_mem [0:1023];

    // reference model state (random phase)
    int   streak;
    bit   owed;
    bit   pend_v;
    bit   pend_if;
    logic [31:0] pend_d, last_if, last_dm;

    task automatic reset_dut(input int cycles);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        // ---------------- reset: both requests high ----------------
        drive(1, 10'h005, 1, 0, 10'h003, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            chk("rst_if_gnt", bus.if_gnt, 0);
            chk("rst_dm_gnt", bus.dm_gnt, 0);
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_if_rvalid", bus.if_rvalid, 0);
            chk("rst_dm_rvalid", bus.dm_rvalid, 0);
        end
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        #1 rst_n = 1'b1; load_mem = 1'b0;
        #3;
        chk("post_rst_dm_gnt", bus.dm_gnt, 1);
        chk("post_rst_if_gnt", bus.if_gnt, 0);
        // reset arrives while the dm read is in flight
        @(posedge clk); #1 rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3 chk("midrd_rst_dm_rvalid", bus.dm_rvalid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #3 chk("midrd_after_dm_rvalid", bus.dm_rvalid, 0);
        chk("midrd_after_if_rvalid", bus.if_rvalid, 0);

        // ---------------- table-driven sequence ----------------
        vt[0]  = mkv(1, 10'h005, 0, 0, 0, 0,               0, 0, 1, 0, 0, 0, 0, 0);
        vt[1]  = mkv(0, 0,       0, 0, 0, 0,               0, 0, 0, 0, 0, 1, 0, 32'h2800000A);
        vt[2]  = mkv(0, 0,       1, 1, 10'h3FF, 32'hAB,    0, 0, 0, 1, 1, 0, 0, 0);
        vt[3]  = mkv(0, 0,       1, 0, 10'h3FF, 0,         0, 0, 0, 1, 0, 0, 0, 0);
        vt[4]  = mkv(0, 0,       0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 1, 32'hAB);
        vt[5]  = mkv(1, 10'h001, 1, 0, 10'h002, 0,         0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 6; k <= 8; k++)
            vt[k] = mkv(1, 10'h001, 1, 0, 10'h002, 0,      0, 0, 0, 1, 0, 0, 1, init_word(2));
        vt[9]  = mkv(1, 10'h001, 1, 0, 10'h002, 0,         0, 0, 1, 0, 0, 0, 1, init_word(2));
        vt[10] = mkv(1, 10'h001, 1, 0, 10'h002, 0,         0, 0, 0, 1, 0, 1, 0, init_word(1));
        vt[11] = mkv(1, 10'h007, 0, 0, 0, 0,               0, 0, 1, 0, 0, 0, 1, init_word(2));
        vt[12] = mkv(1, 10'h007, 0, 0, 0, 0,               0, 1, 0, 0, 0, 0, 0, 0);
        vt[13] = mkv(1, 10'h007, 1, 1, 10'h009, 32'h1234,  1, 0, 0, 1, 1, 0, 0, 0);
        vt[14] = mkv(1, 10'h007, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0, 0);
        vt[15] = mkv(1, 10'h007, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0, 0);
        vt[16] = mkv(1, 10'h007, 1, 0, 10'h009, 0,         0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 17; k <= 19; k++)
            vt[k] = mkv(1, 10'h007, 1, 0, 10'h009, 0,      0, 0, 0, 1, 0, 0, 1, 32'h1234);
        vt[20] = mkv(1, 10'h007, 1, 0, 10'h009, 0,         0, 0, 1, 0, 0, 0, 1, 32'h1234);

        reset_dut(2);
        for (int k = 0; k < NV; k++) begin
            drive(vt[k].ir, vt[k].ia, vt[k].dr, vt[k].dwe, vt[k].da, vt[k].dwd, vt[k].h, vt[k].f);
            #3;
            chk($sformatf("v%0d_if_gnt", k), bus.if_gnt, vt[k].eig);
            chk($sformatf("v%0d_dm_gnt", k), bus.dm_gnt, vt[k].edg);
            chk($sformatf("v%0d_mem_en", k), bus.mem_en, vt[k].eig | vt[k].edg);
            chk($sformatf("v%0d_mem_we", k), bus.mem_we, vt[k].ewe);
            chk($sformatf("v%0d_if_rvalid", k), bus.if_rvalid, vt[k].eirv);
            chk($sformatf("v%0d_dm_rvalid", k), bus.dm_rvalid, vt[k].edrv);
            if (vt[k].eirv) chk($sformatf("v%0d_if_rdata", k), bus.if_rdata, vt[k].erd);
            if (vt[k].edrv) chk($sformatf("v%0d_dm_rdata", k), bus.dm_rdata, vt[k].erd);
            if (vt[k].ewe) ref_mem[vt[k].da] = vt[k].dwd;
            @(posedge clk); #1;
        end

        // ---------------- randomized vs. reference model ----------------
        reset_dut(2);
        streak = 0; owed = 0; pend_v = 0; pend_if = 0; pend_d = 0; last_if = 0; last_dm = 0;
        for (int c = 0; c < 500; c++) begin
            logic ir, dr, dwe, h, f, elig, win_if, win_dm, xirv, xdrv;
            logic [9:0] ia, da;
            logic [31:0] dwd;
            ir  = ($urandom_range(0, 9) < 7);
            dr  = ($urandom_range(0, 9) < 6);
            dwe = $urandom_range(0, 1);
            h   = ($urandom_range(0, 9) == 0);
            f   = ($urandom_range(0, 9) == 0);
            ia  = 10'($urandom);
            da  = 10'($urandom_range(0, 15));
            dwd = $urandom;
            drive(ir, ia, dr, dwe, da, dwd, h, f);
            #3;
            // fetch may go when allowed and either owed a turn or uncontested
            elig   = ir && !h && !f;
            win_if = elig && (owed || !dr);
            win_dm = dr && !win_if;
            xirv   = pend_v && pend_if && !f;
            xdrv   = pend_v && !pend_if;
            chk("rnd_if_gnt", bus.if_gnt, win_if);
            chk("rnd_dm_gnt", bus.dm_gnt, win_dm);
            chk("rnd_mem_en", bus.mem_en, win_if | win_dm);
            chk("rnd_mem_we", bus.mem_we, win_dm & dwe);
            if (win_if) chk("rnd_mem_addr_if", bus.mem_addr, ia);
            if (win_dm) chk("rnd_mem_addr_dm", bus.mem_addr, da);
            if (win_dm && dwe) chk("rnd_mem_wdata", bus.mem_wdata, dwd);
            chk("rnd_if_rvalid", bus.if_rvalid, xirv);
            chk("rnd_dm_rvalid", bus.dm_rvalid, xdrv);
            chk("rnd_if_rdata", bus.if_rdata, xirv ? pend_d : last_if);
            chk("rnd_dm_rdata", bus.dm_rdata, xdrv ? pend_d : last_dm);
            // advance the model past this clock edge
            if (xirv) last_if = pend_d;
            if (xdrv) last_dm = pend_d;
            if (win_if) begin
                streak = 0; owed = 0;
            end else if (elig) begin
                streak++;
                if (streak >= SMAX) owed = 1;
            end else begin
                streak = 0;
            end
            pend_v = 0;
            if (win_if) begin
                pend_v = 1; pend_if = 1; pend_d = ref_mem[ia];
            end else if (win_dm && !dwe) begin
                pend_v = 1; pend_if = 0; pend_d = ref_mem[da];
            end else if (win_dm) begin
                ref_mem[da] = dwd;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
